// File: rtl/peltier_regulator_if.sv
`default_nettype none
// ============================================================================
//  Module   : peltier_regulator_if
//  Purpose  : Handshake bundle between the peltier regulator and the
//             MCP3008 conversion front-end.
//  Signals  : mcp_sample      - conversion request (regulator -> ADC side)
//             mcp_busy        - ADC side busy       (ADC side -> regulator)
//             mcp_data[15:0]  - conversion word, [9:0] = ADC code
//             mcp_data_avail  - conversion word valid
//             mcp_data_accept - one-cycle consume pulse (regulator -> ADC)
//  Modports : master = regulator, slave = ADC front-end
//  Revision : 1.0 - initial release
// ============================================================================
interface peltier_regulator_if;
    logic        mcp_sample;
    logic        mcp_busy;
    logic [15:0] mcp_data;
    logic        mcp_data_avail;
    logic        mcp_data_accept;

    modport master (
        output mcp_sample,
        output mcp_data_accept,
        input  mcp_busy,
        input  mcp_data,
        input  mcp_data_avail
    );

    modport slave (
        input  mcp_sample,
        input  mcp_data_accept,
        output mcp_busy,
        output mcp_data,
        output mcp_data_avail
    );
endinterface
`default_nettype wire

// File: rtl/peltier_regulator.sv
`default_nettype none
// ============================================================================
//  Module   : peltier_regulator
//  Purpose  : Periodically samples a temperature ADC channel, averages
//             2^AVG_LOG2 conversions and drives a proportional peltier
//             PWM duty cycle. Sticky fault on conversion timeout.
//  Ports    : clk, rst        - clock, asynchronous active-high reset
//             enable_i        - regulation on/off
//             setpoint_i[9:0] - target ADC code (larger = warmer)
//             mcp             - ADC handshake (peltier_regulator_if.master)
//             duty_o[7:0]     - PWM duty cycle
//             avg_out_o[9:0]  - last averaged ADC code
//             update_o        - one-cycle pulse when duty/avg_out change
//             fault_o         - sticky conversion-timeout flag
//  Options  : PELTIER_REGULATOR_SLEW_EN - limit duty change to 16 codes
//             per update (default build: duty jumps straight to target)
//  Revision : 1.0 - initial release
// ============================================================================
module peltier_regulator #(
    parameter int SAMPLE_PERIOD = 1000000,
    parameter int AVG_LOG2      = 2,
    parameter int KP_SHIFT      = 2,
    parameter int TIMEOUT       = 4096
) (
    input  wire                 clk,
    input  wire                 rst,
    input  wire                 enable_i,
    input  wire [9:0]           setpoint_i,
    peltier_regulator_if.master mcp,
    output logic [7:0]          duty_o,
    output logic [9:0]          avg_out_o,
    output logic                update_o,
    output logic                fault_o
);

    localparam int ACC_W = 10 + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam int PER_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int SCL_W = 10 + KP_SHIFT;

    localparam logic [PER_W-1:0] PERIOD_LAST  = PER_W'(SAMPLE_PERIOD - 1);
    localparam logic [TO_W-1:0]  TIMEOUT_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SAMPLES_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_TICK = 3'd1,
        REQUEST   = 3'd2,
        WAIT_DATA = 3'd3,
        ACCUM     = 3'd4,
        UPDATE    = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [PER_W-1:0]   period_q, period_d;
    logic               pulse_q, pulse_d;     // second cycle of the request pulse
    logic [TO_W-1:0]    to_q, to_d;
    logic [9:0]         code_q, code_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         duty_q, duty_d;
    logic [9:0]         avg_q, avg_d;
    logic               update_q, update_d;
    logic               fault_q, fault_d;
    logic               enable_q;

    logic               w_sample;
    logic               w_accept;
    logic [9:0]         w_avg;
    logic signed [10:0] w_err;
    logic [SCL_W-1:0]   w_scaled;
    logic [7:0]         w_target;
    logic [7:0]         w_duty_new;
    logic               w_unused_data_hi;

    // Upper bits of the conversion word carry no temperature information.
    assign w_unused_data_hi = ^mcp.mcp_data[15:10];

    // ------------------------------------------------------------------
    // Control law: truncating average, signed error, saturating P-gain
    // ------------------------------------------------------------------
    assign w_avg    = acc_q[ACC_W-1:AVG_LOG2];
    assign w_err    = $signed({1'b0, w_avg}) - $signed({1'b0, setpoint_i});
    // Only consulted when err > 0, so bits [9:0] hold its full magnitude.
    assign w_scaled = SCL_W'(w_err[9:0]) << KP_SHIFT;

    always_comb begin
        w_target = 8'd0;
        if (!w_err[10] && (w_err != 11'sd0)) begin
            w_target = (w_scaled > SCL_W'(255)) ? 8'hFF : w_scaled[7:0];
        end
    end

`ifdef PELTIER_REGULATOR_SLEW_EN
    localparam logic [7:0] SLEW_STEP = 8'd16;

    // Step toward the target; a small remaining gap lands exactly on it,
    // so the result can never pass 0 or 255.
    always_comb begin
        w_duty_new = w_target;
        if (w_target > duty_q) begin
            if ((w_target - duty_q) > SLEW_STEP) begin
                w_duty_new = duty_q + SLEW_STEP;
            end
        end else if ((duty_q - w_target) > SLEW_STEP) begin
            w_duty_new = duty_q - SLEW_STEP;
        end
    end
`else
    assign w_duty_new = w_target;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            period_q <= '0;
            pulse_q  <= 1'b0;
            to_q     <= '0;
            code_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            duty_q   <= '0;
            avg_q    <= '0;
            update_q <= 1'b0;
            fault_q  <= 1'b0;
            enable_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            pulse_q  <= pulse_d;
            to_q     <= to_d;
            code_q   <= code_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            duty_q   <= duty_d;
            avg_q    <= avg_d;
            update_q <= update_d;
            fault_q  <= fault_d;
            enable_q <= enable_i;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and handshake logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        pulse_d  = pulse_q;
        to_d     = to_q;
        code_d   = code_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        duty_d   = duty_q;
        avg_d    = avg_q;
        update_d = 1'b0;
        fault_d  = fault_q;
        w_sample = 1'b0;
        w_accept = 1'b0;

        // Sample-period timer is free running outside IDLE so that requests
        // stay on a fixed grid regardless of how long a conversion takes.
        if (state_q == IDLE) begin
            period_d = '0;
        end else if (period_q == PERIOD_LAST) begin
            period_d = '0;
        end else begin
            period_d = period_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                acc_d    = '0;
                cnt_d    = '0;
                duty_d   = 8'd0;
                pulse_d  = 1'b0;
                to_d     = '0;
                // Drain any stale conversion word left by an abandoned cycle.
                w_accept = mcp.mcp_data_avail;
                if (enable_i) begin
                    state_d = WAIT_TICK;
                end
            end

            WAIT_TICK: begin
                if (period_q == PERIOD_LAST) begin
                    state_d = REQUEST;
                end
            end

            REQUEST: begin
                to_d = '0;
                if (pulse_q) begin
                    w_sample = 1'b1;
                    pulse_d  = 1'b0;
                    state_d  = WAIT_DATA;
                end else if (!mcp.mcp_busy) begin
                    w_sample = 1'b1;
                    pulse_d  = 1'b1;
                end
            end

            WAIT_DATA: begin
                if (mcp.mcp_data_avail) begin
                    w_accept = 1'b1;
                    code_d   = mcp.mcp_data[9:0];
                    state_d  = ACCUM;
                end else if (to_q == TIMEOUT_LAST) begin
                    fault_d  = 1'b1;
                    duty_d   = 8'd0;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = WAIT_TICK;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end

            ACCUM: begin
                acc_d = acc_q + ACC_W'(code_q);
                cnt_d = cnt_q + 1'b1;
                // Remaining samples of a burst are taken back to back.
                state_d = (cnt_q == SAMPLES_LAST) ? UPDATE : REQUEST;
            end

            UPDATE: begin
                avg_d    = w_avg;
                duty_d   = w_duty_new;
                update_d = 1'b1;
                acc_d    = '0;
                cnt_d    = '0;
                state_d  = WAIT_TICK;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Disable wins over everything: drop the drive immediately and
        // abandon any in-flight request. A pending word is still accepted.
        if (!enable_i) begin
            state_d  = IDLE;
            duty_d   = 8'd0;
            update_d = 1'b0;
            acc_d    = '0;
            cnt_d    = '0;
            pulse_d  = 1'b0;
            w_sample = 1'b0;
        end

        if (enable_i && !enable_q) begin
            fault_d = 1'b0;
        end
    end

    // Reset gating keeps the strobes low while rst is held, even with a
    // word waiting on the bus.
    assign mcp.mcp_sample      = w_sample & ~rst;
    assign mcp.mcp_data_accept = w_accept & ~rst;

    assign duty_o    = duty_q;
    assign avg_out_o = avg_q;
    assign update_o  = update_q;
    assign fault_o   = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_peltier_regulator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_peltier_regulator
//  Purpose  : Directed self-checking bench for peltier_regulator with
//             SAMPLE_PERIOD=100, AVG_LOG2=2, KP_SHIFT=2, TIMEOUT=64.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_peltier_regulator;

    localparam int SP = 100;
    localparam int TO = 64;
`ifdef PELTIER_REGULATOR_SLEW_EN
    localparam bit SLEW = 1'b1;
`else
    localparam bit SLEW = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [9:0] setpoint;
    logic [7:0] duty;
    logic [9:0] avg_out;
    logic       update;
    logic       fault;

    int n_pass  = 0;
    int n_total = 0;
    int acc_cnt = 0;
    int upd_cnt = 0;

    peltier_regulator_if bus();

    peltier_regulator #(
        .SAMPLE_PERIOD (SP),
        .AVG_LOG2      (2),
        .KP_SHIFT      (2),
        .TIMEOUT       (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable_i   (enable),
        .setpoint_i (setpoint),
        .mcp        (bus),
        .duty_o     (duty),
        .avg_out_o  (avg_out),
        .update_o   (update),
        .fault_o    (fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mcp_data_accept) acc_cnt <= acc_cnt + 1;
        if (update)              upd_cnt <= upd_cnt + 1;
    end

    // Waits for a request pulse, measures its length, then optionally
    // answers with one conversion word. Caller sits just after a negedge.
    task automatic serve(input logic [15:0] word, input bit answer,
                         output bit ok, output int hi, output bit acc);
        ok = 1'b0; hi = 0; acc = 1'b0;
        for (int i = 0; i < 300; i++) begin
            #1;
            if (bus.mcp_sample) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) return;
        hi = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (bus.mcp_sample) hi++; else break;
        end
        if (!answer) return;
        bus.mcp_data = word; bus.mcp_data_avail = 1'b1;
        #1; acc = bus.mcp_data_accept;
        @(negedge clk);
        bus.mcp_data_avail = 1'b0; bus.mcp_data = 16'h0000;
    endtask

    task automatic run_round(input logic [15:0] w0, input logic [15:0] w1,
                             input logic [15:0] w2, input logic [15:0] w3,
                             output bit served, output bit upd);
        logic [15:0] words [4];
        bit ok, acc; int hi;
        words = '{w0, w1, w2, w3};
        served = 1'b1;
        for (int i = 0; i < 4; i++) begin
            serve(words[i], 1'b1, ok, hi, acc);
            if (!ok || hi != 2 || !acc) served = 1'b0;
        end
        upd = 1'b0;
        for (int i = 0; i < 10 && !upd; i++) begin
            @(negedge clk);
            if (update) upd = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; setpoint = 10'd0;
        bus.mcp_busy = 1'b0; bus.mcp_data = 16'h03FF; bus.mcp_data_avail = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_total++; if (duty !== 8'd0)    $display("FAIL reset_duty: got %0d expected 0", duty); else n_pass++;
        n_total++; if (avg_out !== 10'd0) $display("FAIL reset_avg: got %0d expected 0", avg_out); else n_pass++;
        n_total++; if (update !== 1'b0)  $display("FAIL reset_update: got %b expected 0", update); else n_pass++;
        n_total++; if (fault !== 1'b0)   $display("FAIL reset_fault: got %b expected 0", fault); else n_pass++;
        n_total++; if (bus.mcp_sample !== 1'b0) $display("FAIL reset_sample: got %b expected 0", bus.mcp_sample); else n_pass++;
        n_total++; if (bus.mcp_data_accept !== 1'b0) $display("FAIL reset_accept: got %b expected 0", bus.mcp_data_accept); else n_pass++;
        bus.mcp_data_avail = 1'b0; bus.mcp_data = 16'h0000;
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_average();
        bit served, upd; int a0, u0;
        setpoint = 10'd500; a0 = acc_cnt; u0 = upd_cnt;
        enable = 1'b1;
        run_round(16'h0208, 16'h0208, 16'h0208, 16'h0208, served, upd);
        n_total++; if (served !== 1'b1) $display("FAIL avg_handshake: got %b expected 1", served); else n_pass++;
        n_total++; if (upd !== 1'b1)    $display("FAIL avg_update_seen: got %b expected 1", upd); else n_pass++;
        n_total++; if (avg_out !== 10'd520) $display("FAIL avg_value: got %0d expected 520", avg_out); else n_pass++;
        n_total++; if (duty !== (SLEW ? 8'd16 : 8'd80)) $display("FAIL avg_duty: got %0d expected %0d", duty, SLEW ? 16 : 80); else n_pass++;
        repeat (5) @(negedge clk);
        n_total++; if (acc_cnt - a0 !== 4) $display("FAIL avg_accepts: got %0d expected 4", acc_cnt - a0); else n_pass++;
        n_total++; if (upd_cnt - u0 !== 1) $display("FAIL avg_update_count: got %0d expected 1", upd_cnt - u0); else n_pass++;
    endtask

    task automatic test_saturate();
        bit served, upd;
        logic [7:0] exp_d [3];
        exp_d = SLEW ? '{8'd16, 8'd32, 8'd48} : '{8'd255, 8'd255, 8'd255};
        enable = 1'b0;
        repeat (2) @(negedge clk);
        n_total++; if (duty !== 8'd0) $display("FAIL disable_duty: got %0d expected 0", duty); else n_pass++;
        enable = 1'b1; setpoint = 10'd100;
        for (int r = 0; r < 3; r++) begin
            run_round(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, served, upd);
            n_total++; if ((served && upd) !== 1'b1) $display("FAIL sat_round%0d: got %b expected 1", r, served && upd); else n_pass++;
            n_total++; if (duty !== exp_d[r]) $display("FAIL sat_duty%0d: got %0d expected %0d", r, duty, exp_d[r]); else n_pass++;
        end
        n_total++; if (avg_out !== 10'd1023) $display("FAIL sat_avg: got %0d expected 1023", avg_out); else n_pass++;
        run_round(16'h005A, 16'h005A, 16'h005A, 16'h005A, served, upd);
        n_total++; if ((served && upd) !== 1'b1) $display("FAIL cold_round: got %b expected 1", served && upd); else n_pass++;
        n_total++; if (avg_out !== 10'd90) $display("FAIL cold_avg: got %0d expected 90", avg_out); else n_pass++;
        n_total++; if (duty !== (SLEW ? 8'd32 : 8'd0)) $display("FAIL cold_duty: got %0d expected %0d", duty, SLEW ? 32 : 0); else n_pass++;
    endtask

    task automatic test_truncate();
        bit served, upd;
        setpoint = 10'd240;
        // codes 100, 200, 301, 402 -> sum 1003 -> avg 250; upper bits set on one word
        run_round(16'hFC64, 16'h00C8, 16'h012D, 16'h0192, served, upd);
        n_total++; if ((served && upd) !== 1'b1) $display("FAIL trunc_round: got %b expected 1", served && upd); else n_pass++;
        n_total++; if (avg_out !== 10'd250) $display("FAIL trunc_avg: got %0d expected 250", avg_out); else n_pass++;
        n_total++; if (duty !== 8'd40) $display("FAIL trunc_duty: got %0d expected 40", duty); else n_pass++;
    endtask

    task automatic test_busy();
        bit seen, ok, acc, all_ok, upd; int hi;
        setpoint = 10'd500;
        bus.mcp_busy = 1'b1; seen = 1'b0;
        repeat (150) begin
            @(negedge clk); #1;
            if (bus.mcp_sample) seen = 1'b1;
        end
        n_total++; if (seen !== 1'b0) $display("FAIL busy_hold: got %b expected 0", seen); else n_pass++;
        @(negedge clk); bus.mcp_busy = 1'b0;
        serve(16'h0208, 1'b1, ok, hi, acc);
        n_total++; if (hi !== 2) $display("FAIL busy_pulse_len: got %0d expected 2", hi); else n_pass++;
        n_total++; if ((ok && acc) !== 1'b1) $display("FAIL busy_handshake: got %b expected 1", ok && acc); else n_pass++;
        all_ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            serve(16'h0208, 1'b1, ok, hi, acc);
            if (!ok || hi != 2 || !acc) all_ok = 1'b0;
        end
        upd = 1'b0;
        for (int i = 0; i < 10 && !upd; i++) begin
            @(negedge clk);
            if (update) upd = 1'b1;
        end
        n_total++; if ((all_ok && upd) !== 1'b1) $display("FAIL busy_round: got %b expected 1", all_ok && upd); else n_pass++;
        n_total++; if (duty !== (SLEW ? 8'd56 : 8'd80)) $display("FAIL busy_duty: got %0d expected %0d", duty, SLEW ? 56 : 80); else n_pass++;
    endtask

    task automatic test_timeout();
        bit ok, acc, served, upd; int hi, k;
        serve(16'h0000, 1'b0, ok, hi, acc);
        n_total++; if ((ok && hi == 2) !== 1'b1) $display("FAIL to_request: got ok=%b len=%0d expected ok=1 len=2", ok, hi); else n_pass++;
        k = 0;
        while (!fault && k < 200) begin
            @(negedge clk);
            k++;
        end
        n_total++; if (k !== TO) $display("FAIL to_latency: got %0d expected %0d", k, TO); else n_pass++;
        n_total++; if (duty !== 8'd0) $display("FAIL to_duty: got %0d expected 0", duty); else n_pass++;
        // A successful update afterwards must leave the fault standing.
        run_round(16'h0208, 16'h0208, 16'h0208, 16'h0208, served, upd);
        n_total++; if ((served && upd) !== 1'b1) $display("FAIL to_recover_round: got %b expected 1", served && upd); else n_pass++;
        n_total++; if (fault !== 1'b1) $display("FAIL to_sticky: got %b expected 1", fault); else n_pass++;
        n_total++; if (duty !== (SLEW ? 8'd16 : 8'd80)) $display("FAIL to_recover_duty: got %0d expected %0d", duty, SLEW ? 16 : 80); else n_pass++;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        n_total++; if (fault !== 1'b1) $display("FAIL to_disabled_fault: got %b expected 1", fault); else n_pass++;
        enable = 1'b1;
        @(negedge clk);
        n_total++; if (fault !== 1'b0) $display("FAIL to_clear: got %b expected 0", fault); else n_pass++;
    endtask

    task automatic test_disable_drain();
        bit ok, acc, served, upd; int hi, u0;
        setpoint = 10'd500; u0 = upd_cnt;
        serve(16'h03E8, 1'b1, ok, hi, acc);
        serve(16'h03E8, 1'b1, ok, hi, acc);
        enable = 1'b0;
        @(negedge clk); #1;
        n_total++; if (duty !== 8'd0) $display("FAIL drain_duty: got %0d expected 0", duty); else n_pass++;
        repeat (3) @(negedge clk);
        bus.mcp_data = 16'h03E8; bus.mcp_data_avail = 1'b1;
        #1;
        n_total++; if (bus.mcp_data_accept !== 1'b1) $display("FAIL drain_accept: got %b expected 1", bus.mcp_data_accept); else n_pass++;
        @(negedge clk);
        bus.mcp_data_avail = 1'b0; bus.mcp_data = 16'h0000;
        repeat (3) @(negedge clk);
        n_total++; if (upd_cnt - u0 !== 0) $display("FAIL drain_no_update: got %0d expected 0", upd_cnt - u0); else n_pass++;
        enable = 1'b1;
        run_round(16'h0208, 16'h0208, 16'h0208, 16'h0208, served, upd);
        n_total++; if ((served && upd) !== 1'b1) $display("FAIL drain_fresh_round: got %b expected 1", served && upd); else n_pass++;
        n_total++; if (avg_out !== 10'd520) $display("FAIL drain_fresh_avg: got %0d expected 520", avg_out); else n_pass++;
        n_total++; if (duty !== (SLEW ? 8'd16 : 8'd80)) $display("FAIL drain_fresh_duty: got %0d expected %0d", duty, SLEW ? 16 : 80); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit ok, acc; int hi, k, a0;
        serve(16'h0000, 1'b0, ok, hi, acc);
        a0 = acc_cnt;
        rst = 1'b1;
        #1;
        bus.mcp_data = 16'h0208; bus.mcp_data_avail = 1'b1;
        #1;
        n_total++; if (duty !== 8'd0)     $display("FAIL rstmid_duty: got %0d expected 0", duty); else n_pass++;
        n_total++; if (avg_out !== 10'd0) $display("FAIL rstmid_avg: got %0d expected 0", avg_out); else n_pass++;
        n_total++; if (bus.mcp_sample !== 1'b0) $display("FAIL rstmid_sample: got %b expected 0", bus.mcp_sample); else n_pass++;
        n_total++; if (bus.mcp_data_accept !== 1'b0) $display("FAIL rstmid_accept: got %b expected 0", bus.mcp_data_accept); else n_pass++;
        n_total++; if ((update | fault) !== 1'b0) $display("FAIL rstmid_flags: got %b expected 0", update | fault); else n_pass++;
        @(negedge clk);
        rst = 1'b0; bus.mcp_data_avail = 1'b0; bus.mcp_data = 16'h0000;
        n_total++; if (acc_cnt - a0 !== 0) $display("FAIL rstmid_no_accept: got %0d expected 0", acc_cnt - a0); else n_pass++;
        for (k = 1; k <= 300; k++) begin
            @(negedge clk); #1;
            if (bus.mcp_sample) break;
        end
        n_total++; if (k !== SP + 1) $display("FAIL rstmid_first_request: got %0d expected %0d", k, SP + 1); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_average();
        test_saturate();
        test_truncate();
        test_busy();
        test_timeout();
        test_disable_drain();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
